// File: rtl/dpmem_arbiter.sv
// Two-requester front end for a dual-port memory: independent round-robin
// read and write arbiters, with read data steered back to the issuing requester.
module dpmem_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ready,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_data,
   input  logic              b_valid,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_data,
   output logic [ADDR_W-1:0] mem_ra,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_wa,
   output logic [DATA_W-1:0] mem_wd
);

   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

   req_e rd_ptr;
   req_e wr_ptr;
   logic rsp_vld_p1;
   req_e rsp_owner_p1;

   logic a_rd, b_rd, a_wr, b_wr;
   logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;

   // Grants are suppressed during reset so nothing reaches the memory.
   always_comb begin
      a_rd     = a_valid && !a_write;
      b_rd     = b_valid && !b_write;
      a_wr     = a_valid &&  a_write;
      b_wr     = b_valid &&  b_write;
      rd_gnt_a = !rst && a_rd && (!b_rd || rd_ptr == REQ_A);
      rd_gnt_b = !rst && b_rd && (!a_rd || rd_ptr == REQ_B);
      wr_gnt_a = !rst && a_wr && (!b_wr || wr_ptr == REQ_A);
      wr_gnt_b = !rst && b_wr && (!a_wr || wr_ptr == REQ_B);
      a_ready  = rd_gnt_a || wr_gnt_a;
      b_ready  = rd_gnt_b || wr_gnt_b;
   end

   always_comb begin
      mem_we = 1'b0;
      mem_wa = '0;
      mem_wd = '0;
      mem_ra = '0;
      if (wr_gnt_a) begin
         mem_we = 1'b1;
         mem_wa = a_addr;
         mem_wd = a_wdata;
      end else if (wr_gnt_b) begin
         mem_we = 1'b1;
         mem_wa = b_addr;
         mem_wd = b_wdata;
      end
      if (rd_gnt_a)
         mem_ra = a_addr;
      else if (rd_gnt_b)
         mem_ra = b_addr;
   end

   // Stage p0 -> p1: remember who owns the read the memory is returning next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= REQ_A;
         wr_ptr       <= REQ_A;
         rsp_vld_p1   <= 1'b0;
         rsp_owner_p1 <= REQ_A;
      end else begin
         rsp_vld_p1 <= rd_gnt_a || rd_gnt_b;
         if (rd_gnt_a) begin
            rd_ptr       <= REQ_B;
            rsp_owner_p1 <= REQ_A;
         end else if (rd_gnt_b) begin
            rd_ptr       <= REQ_A;
            rsp_owner_p1 <= REQ_B;
         end
         if (wr_gnt_a)
            wr_ptr <= REQ_B;
         else if (wr_gnt_b)
            wr_ptr <= REQ_A;
      end
   end

   always_comb begin
      a_rsp_valid = rsp_vld_p1 && (rsp_owner_p1 == REQ_A);
      b_rsp_valid = rsp_vld_p1 && (rsp_owner_p1 == REQ_B);
      a_rsp_data  = a_rsp_valid ? mem_rd : '0;
      b_rsp_data  = b_rsp_valid ? mem_rd : '0;
   end

endmodule
